fetch: RTL

FETCH -- requirements
Module: fetch

---
 rtl/arriskv_pkg.sv | 13 +
 rtl/fetch_if.sv | 34 +++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch.sv | 125 ++++++++++++
 4 files changed

// File: rtl/arriskv_pkg.sv
// Shared definitions for the arriskv front end: fetch word geometry and
// the {pc, instr} record handed from fetch to decode.
package arriskv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bundle: redirect from execute, instruction-memory request and
// response channels, and the instruction channel towards decode.
interface fetch_if
    import arriskv_pkg::*;
#(
    parameter int wd_regs_p = XLEN
);

    logic                 i_br_taken;
    logic [wd_regs_p-1:0] i_jmp_addr;
    logic                 o_imem_req_valid;
    logic                 i_imem_req_ready;
    logic [wd_regs_p-1:0] o_imem_addr;
    logic                 i_imem_rsp_valid;
    logic [wd_regs_p-1:0] i_imem_rsp_data;
    logic                 o_instr_valid;
    logic                 i_instr_ready;
    logic [wd_regs_p-1:0] o_instr;
    logic [wd_regs_p-1:0] o_pc;

    // master is the fetch block, slave is the surrounding core/memory
    modport master (
        input  i_br_taken, i_jmp_addr, i_imem_req_ready, i_imem_rsp_valid,
               i_imem_rsp_data, i_instr_ready,
        output o_imem_req_valid, o_imem_addr, o_instr_valid, o_instr, o_pc
    );

    modport slave (
        output i_br_taken, i_jmp_addr, i_imem_req_ready, i_imem_rsp_valid,
               i_imem_rsp_data, i_instr_ready,
        input  o_imem_req_valid, o_imem_addr, o_instr_valid, o_instr, o_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small first-word-fall-through FIFO; the head is read combinationally so a
// word written this cycle is visible on the next one.
module fetch_fifo
    import arriskv_pkg::*;
#(
    parameter int  depth_p = 2,
    parameter type data_t  = logic [XLEN-1:0]
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  data_t                        push_data,
    input  logic                         pop,
    output data_t                        head,
    output logic [$clog2(depth_p+1)-1:0] count
);

    localparam int ptr_w = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int cnt_w = $clog2(depth_p + 1);

    data_t            mem_reg [depth_p];
    logic [ptr_w-1:0] wr_ptr_reg;
    logic [ptr_w-1:0] rd_ptr_reg;
    logic [cnt_w-1:0] count_reg;
    logic             is_empty;
    logic             is_full;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(depth_p - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == cnt_w'(depth_p));
    assign pop_ok   = pop && !is_empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push_ok  = push && (!is_full || pop_ok);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + cnt_w'(1);
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch.sv
// Instruction fetch: credit-limited request issue, in-order response pairing
// through a tag queue, and redirect handling that drops stale responses.
module fetch
    import arriskv_pkg::*;
#(
    parameter int                   wd_regs_p    = XLEN,
    parameter logic [wd_regs_p-1:0] reset_pc_p   = 32'h0000_0000,
    parameter int                   fifo_depth_p = 2
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    localparam int                   cnt_w      = $clog2(fifo_depth_p + 1);
    localparam logic [wd_regs_p-1:0] align_mask = wd_regs_p'(INSTR_BYTES - 1);
    localparam logic [wd_regs_p-1:0] pc_step    = wd_regs_p'(INSTR_BYTES);
    localparam logic [cnt_w:0]       credit_max = (cnt_w + 1)'(fifo_depth_p);

    // Same shape as fetch_entry_t, but sized by this instance's width.
    typedef struct packed {
        logic [wd_regs_p-1:0] pc;
        logic [wd_regs_p-1:0] instr;
    } entry_t;

    logic [wd_regs_p-1:0] pc_reg;
    logic [wd_regs_p-1:0] pc_next;
    logic [cnt_w-1:0]     discard_reg;
    logic [cnt_w-1:0]     discard_next;
    logic [cnt_w-1:0]     outstanding;
    logic [cnt_w-1:0]     fill;
    logic [cnt_w:0]       credit_used;
    logic [wd_regs_p-1:0] tag_pc;
    entry_t               rsp_entry;
    entry_t               instr_head;
    logic                 req_valid;
    logic                 req_fire;
    logic                 rsp_accept;
    logic                 rsp_keep;
    logic                 has_instr;
    logic                 instr_valid;
    logic                 instr_pop;

    // Buffered plus in-flight words never exceed the FIFO depth, so every
    // response always has a slot waiting for it.
    assign credit_used = {1'b0, outstanding} + {1'b0, fill};
    assign req_valid   = !rst && (credit_used < credit_max);
    assign req_fire    = req_valid && bus.i_imem_req_ready;

    assign rsp_accept  = bus.i_imem_rsp_valid && (outstanding != '0);
    assign rsp_keep    = rsp_accept && !bus.i_br_taken && (discard_reg == '0);
    assign rsp_entry   = '{pc: tag_pc, instr: bus.i_imem_rsp_data};

    assign has_instr   = !rst && (fill != '0);
    assign instr_valid = has_instr && !bus.i_br_taken;
    assign instr_pop   = instr_valid && bus.i_instr_ready;

    // Tag-queue occupancy doubles as the outstanding-request counter.
    fetch_fifo #(
        .depth_p (fifo_depth_p),
        .data_t  (logic [wd_regs_p-1:0])
    ) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pc_reg),
        .pop       (rsp_accept),
        .head      (tag_pc),
        .count     (outstanding)
    );

    fetch_fifo #(
        .depth_p (fifo_depth_p),
        .data_t  (entry_t)
    ) u_instr_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.i_br_taken),
        .push      (rsp_keep),
        .push_data (rsp_entry),
        .pop       (instr_pop),
        .head      (instr_head),
        .count     (fill)
    );

    always_comb begin
        pc_next      = pc_reg;
        discard_next = discard_reg;
        if (bus.i_br_taken) begin
            pc_next      = bus.i_jmp_addr & ~align_mask;
            // Everything still owed by memory, including a request leaving
            // this very cycle, belongs to the abandoned path.
            discard_next = outstanding + cnt_w'(req_fire) - cnt_w'(rsp_accept);
        end else begin
            if (req_fire) begin
                pc_next = pc_reg + pc_step;
            end
            if (rsp_accept && (discard_reg != '0)) begin
                discard_next = discard_reg - cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg      <= reset_pc_p;
            discard_reg <= '0;
        end else begin
            pc_reg      <= pc_next;
            discard_reg <= discard_next;
        end
    end

    assign bus.o_imem_req_valid = req_valid;
    assign bus.o_imem_addr      = pc_reg;
    assign bus.o_instr_valid    = instr_valid;
    assign bus.o_instr          = has_instr ? instr_head.instr : '0;
    assign bus.o_pc             = has_instr ? instr_head.pc : '0;

    // A response with nothing outstanding is a memory protocol error.
    a_rsp_without_req: assert property (@(posedge clk) disable iff (rst)
        !(bus.i_imem_rsp_valid && (outstanding == '0)));

endmodule
